avalon_burst_slave: RTL and testbench
=====================================

Name: avalon_burst_slave

Overview:
- Parametrised Avalon-MM slave front end for the accelerator's local SRAM.
- Successor to the single-beat/burst-write controller: adds burst reads, parametrised widths and address range, write-burst flow control, per-burst error responses, and a registered memory-side port.
- Sits between the Avalon fabric and the on-chip result/coefficient memory.

Parameters:
- ADDR_W, 13, Avalon address width.
- MEM_ADDR_W, 11, memory address width; MAX_ADDR must be < 2**MEM_ADDR_W.
- DATA_W, 32, data width.
- BURST_W, 10, burstcount width.
- MAX_ADDR, 11'h62C, highest legal word address.

Ports:
- clk  in  1  system clock
- n_rst  in  1  asynchronous active-low reset
- read  in  1  Avalon read request
- write  in  1  Avalon write request
- beginbursttransfer  in  1  burst qualifier; burstcount sampled only when high
- burstcount  in  BURST_W  beats in burst
- address  in  ADDR_W  word address
- writedata  in  DATA_W  write beat data
- waitrequest  out  1  slave stall
- readdata  out  DATA_W  read beat data
- readdatavalid  out  1  read beat valid
- writeresponsevalid  out  1  write burst response strobe
- response  out  2  00 OKAY, 10 SLAVEERROR, 11 DECODEERROR
- mem_addr  out  MEM_ADDR_W  memory address (registered)
- mem_wen  out  1  memory write enable (registered)
- mem_ren  out  1  memory read enable (registered)
- mem_wdata  out  DATA_W  memory write data (registered)
- mem_rdata  in  DATA_W  memory read data, valid exactly 1 cycle after mem_ren

Behaviour:
- Reset: one clock, asynchronous active-low reset. State returns to IDLE; every output register, beat counter and error flag goes to 0; waitrequest=0. Reset mid-burst abandons the burst with no response and no further memory access.
- States: IDLE, WR_BURST, WR_RESP, RD_BURST, RD_DRAIN, ERR_RESP.
- IDLE, command acceptance:
  - waitrequest=0; a command is accepted in any cycle with read or write high.
  - Burst length len = burstcount if beginbursttransfer=1, else 1; burstcount=0 is treated as 1.
  - Base address latched.
  - Range check uses ADDR_W+1 bits (no overflow): err = (address + len - 1 > MAX_ADDR).
  - read=1 and write=1 together -> ERR_RESP with response 10. That single-cycle response is returned on writeresponsevalid+readdatavalid together; no memory access.
- Write path:
  - The accepted command cycle is beat 0.
  - len=1 -> WR_RESP; else -> WR_BURST.
  - WR_BURST: waitrequest=0; each cycle with write=1 consumes one beat, write=0 stalls and the counter holds. After beat len-1 -> WR_RESP.
  - Beat k consumed in cycle t -> in cycle t+1: mem_wen=1, mem_addr=base+k (low MEM_ADDR_W bits), mem_wdata=writedata. Suppressed (mem_wen=0) if err.
  - WR_RESP: waitrequest=1; writeresponsevalid=1 for exactly one cycle, response=11 if err else 00; -> IDLE.
- Read path:
  - Accept -> RD_BURST, waitrequest=1 until back in IDLE.
  - RD_BURST issues one read per cycle: mem_ren=1, mem_addr=base+i for i=0..len-1. Under err, mem_ren=0 but the beat timing is unchanged.
  - Beat i: readdatavalid=1 in the cycle after its issue. readdata=mem_rdata, or 0 when err; response=11 on every beat if err, else 00.
  - After the last issue -> RD_DRAIN, which returns the final beat -> IDLE.
  - Timing for a read of len N accepted in cycle 0: beats in cycles 2..N+1, new command accepted in cycle N+2.
- response=00 whenever neither strobe is high. readdatavalid and writeresponsevalid are never high in the same cycle except in ERR_RESP.
- Beat counter is BURST_W bits, cleared on every entry to IDLE. Address increment wraps modulo 2**MEM_ADDR_W, which is unreachable when the range check passes.

Test Plan:
- Single write: addr=5, data=DEADBEEF -> cycle 1: mem_wen=1, mem_addr=5, mem_wdata=DEADBEEF; cycle 1 writeresponsevalid=1, response=00.
- Burst write of 4 beats at 0x100 with write deasserted for 2 cycles after beat 1 -> mem_wen at addresses 0x100..0x103 in order, no write during the stall, one writeresponsevalid with response=00.
- Burst read of 3 beats at 0x62A (mem model returns addr) -> readdatavalid in cycles 2,3,4 with data 62A,62B,62C, response=00, waitrequest=0 again in cycle 5.
- Out-of-range burst read at 0x62B, burstcount=3 -> 3 beats with response=11, readdata=0, mem_ren never asserted. Out-of-range burst write of 2 at 0x62C -> both beats consumed, no mem_wen, response=11.
- read=write=1 in IDLE -> one cycle with both strobes high and response=10, no memory access; burstcount=0 with beginbursttransfer=1 behaves as len 1.
- n_rst pulsed low during beat 2 of an 8-beat write -> all outputs 0 immediately, no response; the next command after release behaves normally.

Source files
------------

// File: rtl/avalon_burst_slave_if.sv
// Avalon-MM burst bus between the fabric (master) and the SRAM front end (slave).
interface avalon_burst_slave_if #(
  parameter int ADDR_W  = 13,
  parameter int DATA_W  = 32,
  parameter int BURST_W = 10
);
  logic               read;
  logic               write;
  logic               beginbursttransfer;
  logic [BURST_W-1:0] burstcount;
  logic [ADDR_W-1:0]  address;
  logic [DATA_W-1:0]  writedata;
  logic               waitrequest;
  logic [DATA_W-1:0]  readdata;
  logic               readdatavalid;
  logic               writeresponsevalid;
  logic [1:0]         response;

  modport master (
    output read, write, beginbursttransfer, burstcount, address, writedata,
    input  waitrequest, readdata, readdatavalid, writeresponsevalid, response
  );

  modport slave (
    input  read, write, beginbursttransfer, burstcount, address, writedata,
    output waitrequest, readdata, readdatavalid, writeresponsevalid, response
  );
endinterface

// File: rtl/avalon_burst_slave.sv
// Avalon-MM burst slave in front of the local SRAM: burst reads/writes, range
// checking with per-burst error responses, and a registered memory-side port.
//   state    | meaning
//   IDLE     | accepting a command, waitrequest low
//   WR_BURST | consuming write beats 1..len-1, write low stalls
//   WR_RESP  | single-cycle write response
//   RD_BURST | issuing one memory read per cycle
//   RD_DRAIN | returning the final read beat
//   ERR_RESP | read+write collision, SLAVEERROR on both strobes
module avalon_burst_slave #(
  parameter int                    ADDR_W     = 13,
  parameter int                    MEM_ADDR_W = 11,
  parameter int                    DATA_W     = 32,
  parameter int                    BURST_W    = 10,
  parameter logic [MEM_ADDR_W-1:0] MAX_ADDR   = 11'h62C
) (
  input  logic                  clk,
  input  logic                  n_rst,
  avalon_burst_slave_if.slave   bus,
  output logic [MEM_ADDR_W-1:0] mem_addr,
  output logic                  mem_wen,
  output logic                  mem_ren,
  output logic [DATA_W-1:0]     mem_wdata,
  input  logic [DATA_W-1:0]     mem_rdata
);

  typedef enum logic [2:0] {
    IDLE, WR_BURST, WR_RESP, RD_BURST, RD_DRAIN, ERR_RESP
  } state_t;

  localparam logic [BURST_W-1:0] ONE_B   = BURST_W'(1);
  localparam logic [ADDR_W:0]    ONE_A   = (ADDR_W+1)'(1);
  localparam logic [ADDR_W:0]    MAX_EXT = (ADDR_W+1)'(MAX_ADDR);

  state_t                  state_q, state_d;
  logic [BURST_W-1:0]      cnt_q, cnt_d;
  logic [BURST_W-1:0]      len_q, len_d;
  logic [MEM_ADDR_W-1:0]   base_q, base_d;
  logic                    err_q, err_d;
  logic                    rd_issue_q, rd_issue_d;
  logic                    rd_vld_q;
  logic [MEM_ADDR_W-1:0]   addr_d;
  logic                    wen_d, ren_d;
  logic [DATA_W-1:0]       wdata_d;

  logic [BURST_W-1:0]      cmd_len;
  logic [ADDR_W:0]         cmd_last;
  logic                    cmd_err;
  logic [MEM_ADDR_W-1:0]   cmd_base;

  // One extra bit on the last-address sum so a top-of-space burst cannot wrap into range
  always_comb begin
    cmd_len  = (bus.beginbursttransfer && (bus.burstcount != '0)) ? bus.burstcount : ONE_B;
    cmd_last = {1'b0, bus.address} + (ADDR_W+1)'(cmd_len) - ONE_A;
    cmd_err  = (cmd_last > MAX_EXT);
    cmd_base = bus.address[MEM_ADDR_W-1:0];
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    len_d      = len_q;
    base_d     = base_q;
    err_d      = err_q;
    rd_issue_d = 1'b0;
    addr_d     = mem_addr;
    wen_d      = 1'b0;
    ren_d      = 1'b0;
    wdata_d    = mem_wdata;

    case (state_q)
      IDLE: begin
        if (bus.read && bus.write) begin
          state_d = ERR_RESP;
        end else if (bus.write) begin
          base_d  = cmd_base;
          len_d   = cmd_len;
          err_d   = cmd_err;
          addr_d  = cmd_base;
          wen_d   = !cmd_err;
          wdata_d = bus.writedata;
          cnt_d   = ONE_B;
          state_d = (cmd_len == ONE_B) ? WR_RESP : WR_BURST;
        end else if (bus.read) begin
          base_d     = cmd_base;
          len_d      = cmd_len;
          err_d      = cmd_err;
          addr_d     = cmd_base;
          ren_d      = !cmd_err;
          rd_issue_d = 1'b1;
          cnt_d      = ONE_B;
          state_d    = RD_BURST;
        end
      end
      WR_BURST: begin
        if (bus.write) begin
          addr_d  = base_q + MEM_ADDR_W'(cnt_q);
          wen_d   = !err_q;
          wdata_d = bus.writedata;
          cnt_d   = cnt_q + ONE_B;
          if (cnt_q == len_q - ONE_B) state_d = WR_RESP;
        end
      end
      RD_BURST: begin
        // Beat timing is kept under error; only the memory strobe is masked
        if (cnt_q < len_q) begin
          addr_d     = base_q + MEM_ADDR_W'(cnt_q);
          ren_d      = !err_q;
          rd_issue_d = 1'b1;
          cnt_d      = cnt_q + ONE_B;
        end else begin
          state_d = RD_DRAIN;
        end
      end
      WR_RESP:  state_d = IDLE;
      RD_DRAIN: state_d = IDLE;
      ERR_RESP: state_d = IDLE;
      default:  state_d = IDLE;
    endcase

    if (state_d == IDLE) cnt_d = '0;
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      len_q      <= '0;
      base_q     <= '0;
      err_q      <= 1'b0;
      rd_issue_q <= 1'b0;
      rd_vld_q   <= 1'b0;
      mem_addr   <= '0;
      mem_wen    <= 1'b0;
      mem_ren    <= 1'b0;
      mem_wdata  <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      len_q      <= len_d;
      base_q     <= base_d;
      err_q      <= err_d;
      rd_issue_q <= rd_issue_d;
      rd_vld_q   <= rd_issue_q;
      mem_addr   <= addr_d;
      mem_wen    <= wen_d;
      mem_ren    <= ren_d;
      mem_wdata  <= wdata_d;
    end
  end

  always_comb begin
    bus.waitrequest        = !((state_q == IDLE) || (state_q == WR_BURST));
    bus.writeresponsevalid = (state_q == WR_RESP) || (state_q == ERR_RESP);
    bus.readdatavalid      = rd_vld_q || (state_q == ERR_RESP);
    bus.readdata           = (rd_vld_q && !err_q) ? mem_rdata : '0;
    bus.response           = 2'b00;
    if (state_q == ERR_RESP)                   bus.response = 2'b10;
    else if ((state_q == WR_RESP) || rd_vld_q) bus.response = err_q ? 2'b11 : 2'b00;
  end

endmodule

// File: tb/tb_avalon_burst_slave.sv
// Directed plus randomized bench for avalon_burst_slave; expectations come from
// a transaction-level model (beat timing rules and an associative shadow memory).
module tb_avalon_burst_slave;
  localparam int ADDR_W     = 13;
  localparam int MEM_ADDR_W = 11;
  localparam int DATA_W     = 32;
  localparam int BURST_W    = 10;
  localparam int MAX_ADDR   = 'h62C;

  logic                  clk = 1'b0;
  logic                  n_rst;
  logic [MEM_ADDR_W-1:0] mem_addr;
  logic                  mem_wen, mem_ren;
  logic [DATA_W-1:0]     mem_wdata, mem_rdata;

  // Memory stores data XOR address so unwritten words read back as their address
  bit   [DATA_W-1:0]     mem_x [2048];
  logic [DATA_W-1:0]     ref_mem [int];

  int n_cmp = 0;
  int n_err = 0;

  avalon_burst_slave_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .BURST_W(BURST_W)) bus ();

  avalon_burst_slave #(
    .ADDR_W(ADDR_W), .MEM_ADDR_W(MEM_ADDR_W), .DATA_W(DATA_W),
    .BURST_W(BURST_W), .MAX_ADDR(11'h62C)
  ) dut (
    .clk       (clk),
    .n_rst     (n_rst),
    .bus       (bus.slave),
    .mem_addr  (mem_addr),
    .mem_wen   (mem_wen),
    .mem_ren   (mem_ren),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_wen) mem_x[mem_addr] <= mem_wdata ^ {21'b0, mem_addr};
    mem_rdata <= mem_x[mem_addr] ^ {21'b0, mem_addr};
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_lookup(input logic [10:0] x);
    return ref_mem.exists(int'(x)) ? ref_mem[int'(x)] : {21'b0, x};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.read = 1'b0;
    bus.write = 1'b0;
    bus.beginbursttransfer = 1'b0;
    bus.burstcount = '0;
    bus.address = '0;
    bus.writedata = '0;
  endtask

  task automatic zero_checks(input string tag);
    chk({tag, "_wait"}, bus.waitrequest, 0);
    chk({tag, "_rdv"}, bus.readdatavalid, 0);
    chk({tag, "_wrv"}, bus.writeresponsevalid, 0);
    chk({tag, "_rsp"}, bus.response, 0);
    chk({tag, "_rdata"}, bus.readdata, 0);
    chk({tag, "_wen"}, mem_wen, 0);
    chk({tag, "_ren"}, mem_ren, 0);
    chk({tag, "_maddr"}, mem_addr, 0);
    chk({tag, "_mwdata"}, mem_wdata, 0);
  endtask

  // Command cycle: the slave is idle, so no strobes and no memory access yet
  task automatic cmd_checks(input string tag);
    @(negedge clk);
    chk({tag, "_wait"}, bus.waitrequest, 0);
    chk({tag, "_rdv"}, bus.readdatavalid, 0);
    chk({tag, "_wrv"}, bus.writeresponsevalid, 0);
    chk({tag, "_rsp"}, bus.response, 0);
    chk({tag, "_wen"}, mem_wen, 0);
    chk({tag, "_ren"}, mem_ren, 0);
  endtask

  task automatic do_write(input logic [12:0] a, input logic [9:0] bc, input logic bbt,
                          input logic [31:0] d0, input int stall_at, input int stall_n,
                          input bit rnd_stall);
    int len, k, pk, stall_left, extra;
    bit err, pend, resp, done, stl;
    logic [31:0] d;
    logic [10:0] ma;
    len = (bbt && bc != 0) ? int'(bc) : 1;
    err = (int'(a) + len - 1) > MAX_ADDR;
    bus.read = 1'b0;
    bus.write = 1'b1;
    bus.beginbursttransfer = bbt;
    bus.burstcount = bc;
    bus.address = a;
    bus.writedata = d0;
    cmd_checks("wr_cmd");
    pend = 1'b1; pk = 0; d = d0; k = 1; done = 1'b0; extra = 0;
    stall_left = (stall_at == 0) ? stall_n : 0;
    for (int c = 1; c <= len + stall_n + 12 && !done; c++) begin
      tick();
      ma = a[10:0] + 11'(pk);
      resp = (k == len);
      bus.read = 1'b0;
      bus.beginbursttransfer = 1'b0;
      bus.burstcount = '0;
      bus.address = '0;
      bus.writedata = $urandom;
      if (resp) begin
        bus.write = 1'b0;
      end else begin
        stl = (stall_left > 0) || (rnd_stall && extra < 4 && $urandom_range(0, 2) == 0);
        if (stl) begin
          bus.write = 1'b0;
          if (stall_left > 0) stall_left--;
          else extra++;
        end else begin
          bus.write = 1'b1;
        end
      end
      @(negedge clk);
      chk("wr_wen", mem_wen, pend && !err);
      if (pend && !err) begin
        chk("wr_maddr", mem_addr, ma);
        chk("wr_mwdata", mem_wdata, d);
        ref_mem[int'(ma)] = d;
      end
      chk("wr_rspv", bus.writeresponsevalid, resp);
      chk("wr_rsp", bus.response, resp ? (err ? 3 : 0) : 0);
      chk("wr_wait", bus.waitrequest, resp);
      chk("wr_rdv", bus.readdatavalid, 0);
      pend = 1'b0;
      if (resp) begin
        done = 1'b1;
      end else if (bus.write) begin
        pend = 1'b1;
        pk = k;
        d = bus.writedata;
        if (k == stall_at) stall_left = stall_n;
        k++;
      end
    end
    chk("wr_done", done, 1);
    tick();
    idle();
  endtask

  task automatic do_read(input logic [12:0] a, input logic [9:0] bc, input logic bbt);
    int len;
    bit err;
    len = (bbt && bc != 0) ? int'(bc) : 1;
    err = (int'(a) + len - 1) > MAX_ADDR;
    bus.read = 1'b1;
    bus.write = 1'b0;
    bus.beginbursttransfer = bbt;
    bus.burstcount = bc;
    bus.address = a;
    bus.writedata = $urandom;
    cmd_checks("rd_cmd");
    for (int c = 1; c <= len + 1; c++) begin
      tick();
      idle();
      @(negedge clk);
      chk("rd_wait", bus.waitrequest, 1);
      chk("rd_ren", mem_ren, (c <= len) && !err);
      if (c <= len && !err) chk("rd_maddr", mem_addr, a[10:0] + 11'(c - 1));
      chk("rd_rdv", bus.readdatavalid, c >= 2);
      chk("rd_wrv", bus.writeresponsevalid, 0);
      chk("rd_wen", mem_wen, 0);
      if (c >= 2) begin
        chk("rd_data", bus.readdata, err ? 32'h0 : ref_lookup(a[10:0] + 11'(c - 2)));
        chk("rd_rsp", bus.response, err ? 3 : 0);
      end else begin
        chk("rd_rsp_idle", bus.response, 0);
      end
    end
    tick();
  endtask

  task automatic do_both(input logic [12:0] a);
    bus.read = 1'b1;
    bus.write = 1'b1;
    bus.beginbursttransfer = 1'b1;
    bus.burstcount = 10'd4;
    bus.address = a;
    bus.writedata = $urandom;
    cmd_checks("both_cmd");
    tick();
    idle();
    @(negedge clk);
    chk("both_wrv", bus.writeresponsevalid, 1);
    chk("both_rdv", bus.readdatavalid, 1);
    chk("both_rsp", bus.response, 2);
    chk("both_wen", mem_wen, 0);
    chk("both_ren", mem_ren, 0);
    tick();
  endtask

  initial begin
    logic [12:0] ra;
    int sel;
    idle();
    n_rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    zero_checks("rst");
    n_rst = 1'b1;

    do_write(13'h005, 10'd0, 1'b0, 32'hDEADBEEF, -1, 0, 1'b0);
    do_write(13'h100, 10'd4, 1'b1, 32'h11110000, 1, 2, 1'b0);
    do_read(13'h62A, 10'd3, 1'b1);
    do_read(13'h62B, 10'd3, 1'b1);
    do_write(13'h62C, 10'd2, 1'b1, 32'hCAFEF00D, -1, 0, 1'b0);
    do_both(13'h040);
    do_read(13'h010, 10'd0, 1'b1);
    do_write(13'h020, 10'd0, 1'b1, 32'h12345678, -1, 0, 1'b0);
    do_read(13'h100, 10'd4, 1'b1);
    do_read(13'h005, 10'd7, 1'b0);
    do_read(13'h1FFF, 10'd2, 1'b1);

    // Reset pulse during beat 2 of an 8-beat write
    bus.write = 1'b1;
    bus.beginbursttransfer = 1'b1;
    bus.burstcount = 10'd8;
    bus.address = 13'h200;
    bus.writedata = 32'hA0A0A0A0;
    cmd_checks("mid_cmd");
    tick();
    bus.beginbursttransfer = 1'b0;
    bus.writedata = 32'hA1A1A1A1;
    @(negedge clk);
    chk("mid_wen0", mem_wen, 1);
    chk("mid_maddr0", mem_addr, 11'h200);
    chk("mid_wdata0", mem_wdata, 32'hA0A0A0A0);
    ref_mem['h200] = 32'hA0A0A0A0;
    tick();
    bus.writedata = 32'hA2A2A2A2;
    #2;
    n_rst = 1'b0;
    #1;
    zero_checks("mid_rst");
    @(negedge clk);
    @(posedge clk);
    #1;
    n_rst = 1'b1;
    idle();
    @(negedge clk);
    chk("post_rst_wrv", bus.writeresponsevalid, 0);
    chk("post_rst_wen", mem_wen, 0);
    tick();
    do_write(13'h300, 10'd3, 1'b1, 32'h55AA55AA, -1, 0, 1'b1);
    do_read(13'h200, 10'd2, 1'b1);
    do_read(13'h300, 10'd3, 1'b1);

    for (int i = 0; i < 40; i++) begin
      sel = $urandom_range(0, 9);
      if ($urandom_range(0, 3) == 0) ra = 13'(MAX_ADDR - $urandom_range(0, 6));
      else if (sel == 9) ra = 13'($urandom_range(MAX_ADDR + 1, 'h1FFF));
      else ra = 13'($urandom_range(0, MAX_ADDR));
      if (sel < 4)
        do_write(ra, 10'($urandom_range(0, 9)), 1'($urandom_range(0, 3) != 0), $urandom, -1, 0, 1'b1);
      else if (sel == 8)
        do_both(ra);
      else
        do_read(ra, 10'($urandom_range(0, 9)), 1'($urandom_range(0, 3) != 0));
    end

    idle();
    repeat (2) tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
